decode_scan: RTL and testbench
==============================

DECODE_SCAN -- requirements
Module: decode_scan

Interface
REQ-001 Parameter SEL_W, default 3, shall set the select width; SEL_W range is 1..6.
REQ-002 Parameter DWELL_W, default 16, shall set the dwell-counter width.
REQ-003 Derived constant N_OUT = 2**SEL_W shall set the output count; it is not overridable.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port enable, input, 1: 1 = outputs driven; 0 = all outputs inactive (high).
REQ-007 Port mode, input, 1: 0 = direct decode; 1 = auto-scan.
REQ-008 Port data_in, input, SEL_W: index to decode in direct mode.
REQ-009 Port load, input, 1: direct-mode strobe that captures data_in.
REQ-010 Port dwell, input, DWELL_W: scan hold time, in cycles minus one, per position.
REQ-011 Port data_out, output, N_OUT: registered one-cold output; bit k low selects position k.
REQ-012 Port sel_out, output, SEL_W: registered index currently decoded or pending.
REQ-013 Port wrap, output, 1: registered one-cycle pulse when the scan index wraps from N_OUT-1 to 0.

Function
REQ-014 The state machine shall have states OFF, DIRECT and SCAN, plus BLANK only when configured (REQ-028).
REQ-015 enable=0 in any state shall move to OFF on the next edge. OFF actions:
- data_out = all ones
- sel_out = 0
- dwell counter = 0
- wrap = 0
REQ-016 From OFF with enable=1, the next edge shall enter DIRECT if mode=0 and SCAN if mode=1.
REQ-017 In DIRECT, load=1 at edge t shall set the following at edge t+1:
- sel_out = data_in
- data_out = ~(1 << data_in)
REQ-018 In DIRECT with load=0, data_out and sel_out shall hold their values.
REQ-019 In SCAN, load shall be ignored.
REQ-020 In SCAN, the dwell counter shall increment each cycle. When count >= dwell, the next edge shall apply all of the following:
- clear the counter
- set sel_out to sel_out+1, modulo N_OUT
- update data_out to match the new sel_out
REQ-021 dwell shall be compared live each cycle. dwell=0 shall advance every cycle. Reducing dwell below the current count shall advance on the next edge.
REQ-022 wrap shall be 1 for exactly the one cycle in which sel_out first shows 0 after N_OUT-1; it shall be 0 at all other times, including scan entry.
REQ-023 Entering SCAN from any state shall start at sel_out=0 with data_out = ~1 and the counter at 0, on the entry edge.
REQ-024 A mode change while enabled shall take effect on the next edge.
- DIRECT to SCAN: as REQ-023.
- SCAN to DIRECT: hold the current sel_out and data_out until the next load.
REQ-025 If enable=0 and load=1 occur together, enable=0 shall win.
REQ-026 data_out shall never have more than one bit low in any cycle.

Reset
REQ-027 While rst_n=0, the block shall be in these states:
- state OFF
- data_out = all ones
- sel_out = 0
- counter = 0
- wrap = 0
The first transition out of OFF shall occur on the first edge after rst_n rises.

Configuration
REQ-028 With macro DECODE_SCAN_BLANK_EN defined, each SCAN advance shall first spend one BLANK cycle:
- data_out = all ones
- sel_out = next index already
The decoded next position shall appear one edge later.
- wrap shall be asserted with the decoded 0, not during BLANK.
- Per-position period = dwell+2 cycles.
- Without the macro, there is no BLANK state and the period is dwell+1 cycles.

Structure
REQ-029 A shared package decode_scan_pkg shall hold the state enum (OFF, DIRECT, SCAN, BLANK) and the default SEL_W and DWELL_W constants.
REQ-030 The one-cold decode shall be a combinational sub-module onecold_dec, parametrised by SEL_W, whose output is registered in decode_scan.

Verification
REQ-031 Reset with SEL_W=3, enable=1, mode=0, load pulse with data_in=5 -> one cycle later, data_out=8'b11011111 and sel_out=5.
REQ-032 mode=1, dwell=2, no blank -> sel_out steps 0,1,...,7,0 every 3 cycles; wrap is high exactly in the cycle sel_out returns to 0.
REQ-033 Same as REQ-032 with DECODE_SCAN_BLANK_EN defined -> each step is preceded by one all-ones cycle; the period is 4 cycles.
REQ-034 Scanning at sel_out=4, drop enable for 1 cycle -> data_out=8'hFF; on re-entry, restart at sel_out=0 with data_out=8'hFE.
REQ-035 Assert rst_n=0 asynchronously mid-dwell -> outputs go to 8'hFF/0 immediately, without a clock edge.
REQ-036 SEL_W=4, dwell=0, mode=1 -> sel_out advances every cycle through 0..15; an assertion checks that at most one data_out bit is low in every cycle.

Source files
------------

// File: rtl/decode_scan_pkg.sv
// Shared definitions for the decode_scan block: state encoding and the
// default widths used by the top-level parameters.
package decode_scan_pkg;

  // BLANK is only reachable when DECODE_SCAN_BLANK_EN is defined.
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_BLANK  = 2'd3
  } state_t;

  localparam int DEFAULT_SEL_W   = 3;
  localparam int DEFAULT_DWELL_W = 16;

endpackage

// File: rtl/onecold_dec.sv
// Combinational one-cold decoder: output bit i_idx is low, all others high.
// The caller registers the result.
module onecold_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      i_idx,
  output logic [(2**SEL_W)-1:0] o_dec
);

  // Start from all-inactive and pull exactly the selected bit low.
  always_comb begin
    o_dec        = '1;
    o_dec[i_idx] = 1'b0;
  end

endmodule

// File: rtl/decode_scan.sv
// decode_scan: one-cold output driver with a direct (load-strobed) decode
// mode and an auto-scan mode that walks every position with a live dwell.
// Optional feature macro: DECODE_SCAN_BLANK_EN inserts one all-ones BLANK
// cycle ahead of every scan advance (period becomes dwell+2).
module decode_scan
  import decode_scan_pkg::*;
#(
  parameter int SEL_W   = DEFAULT_SEL_W,
  parameter int DWELL_W = DEFAULT_DWELL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      data_in,
  input  logic                  load,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] data_out,
  output logic [SEL_W-1:0]      sel_out,
  output logic                  wrap
);

  localparam int N_OUT = 2**SEL_W;

  state_t             r_state;
  logic [N_OUT-1:0]   r_dataOut;
  logic [SEL_W-1:0]   r_sel;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_wrap;

  state_t             w_nState;
  logic [SEL_W-1:0]   w_nSel;
  logic [DWELL_W-1:0] w_nCnt;
  logic               w_nWrap;
  logic               w_blankOut;
  logic               w_decodeOut;
  logic               w_advance;
  logic [N_OUT-1:0]   w_dec;

  // The single decoder always looks at the index that will be shown next,
  // so data_out and sel_out can never disagree.
  onecold_dec #(.SEL_W(SEL_W)) u_dec (
    .i_idx (w_nSel),
    .o_dec (w_dec)
  );

  // Next-state and next-output selection; dwell is compared live each cycle.
  always_comb begin
    w_nState    = r_state;
    w_nSel      = r_sel;
    w_nCnt      = r_cnt;
    w_nWrap     = 1'b0;
    w_blankOut  = 1'b0;
    w_decodeOut = 1'b0;
    w_advance   = (r_cnt >= dwell);

    if (!enable) begin
      w_nState   = ST_OFF;
      w_nSel     = '0;
      w_nCnt     = '0;
      w_blankOut = 1'b1;
    end else begin
      case (r_state)
        ST_OFF, ST_DIRECT: begin
          if (mode) begin
            w_nState    = ST_SCAN;
            w_nSel      = '0;
            w_nCnt      = '0;
            w_decodeOut = 1'b1;
          end else begin
            w_nState = ST_DIRECT;
            if (r_state == ST_DIRECT && load) begin
              w_nSel      = data_in;
              w_decodeOut = 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (!mode) begin
            w_nState = ST_DIRECT;
          end else if (w_advance) begin
            w_nCnt = '0;
            w_nSel = r_sel + 1'b1;
`ifdef DECODE_SCAN_BLANK_EN
            w_nState   = ST_BLANK;
            w_blankOut = 1'b1;
`else
            w_decodeOut = 1'b1;
            w_nWrap     = (r_sel == '1);
`endif
          end else begin
            w_nCnt = r_cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          if (!mode) begin
            w_nState = ST_DIRECT;
          end else begin
            w_nState    = ST_SCAN;
            w_nCnt      = '0;
            w_decodeOut = 1'b1;
            w_nWrap     = (r_sel == '0);
          end
        end
        default: begin
          w_nState   = ST_OFF;
          w_nSel     = '0;
          w_nCnt     = '0;
          w_blankOut = 1'b1;
        end
      endcase
    end
  end

  // State and output registers; reset forces the inactive OFF picture at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_OFF;
      r_dataOut <= '1;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_state <= w_nState;
      r_sel   <= w_nSel;
      r_cnt   <= w_nCnt;
      r_wrap  <= w_nWrap;
      if (w_blankOut) begin
        r_dataOut <= '1;
      end else if (w_decodeOut) begin
        r_dataOut <= w_dec;
      end
    end
  end

  assign data_out = r_dataOut;
  assign sel_out  = r_sel;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_decode_scan.sv
// Directed testbench for decode_scan: an 8-output instance exercising direct
// decode, scanning, enable drop, live dwell, mode changes and async reset,
// plus a 16-output instance scanning with dwell=0. Expectations follow
// DECODE_SCAN_BLANK_EN when it is defined.
module tb_decode_scan;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        mode;
  logic [2:0]  dataIn;
  logic        load;
  logic [15:0] dwell;
  logic [7:0]  dataOut;
  logic [2:0]  selOut;
  logic        wrap;

  logic        rst4N;
  logic        enable4;
  logic        mode4;
  logic [3:0]  dataIn4;
  logic        load4;
  logic [15:0] dwell4;
  logic [15:0] dataOut4;
  logic [3:0]  selOut4;
  logic        wrap4;

  int          compared;
  int          mismatched;
  logic [2:0]  expSel;

  decode_scan #(.SEL_W(3), .DWELL_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .mode     (mode),
    .data_in  (dataIn),
    .load     (load),
    .dwell    (dwell),
    .data_out (dataOut),
    .sel_out  (selOut),
    .wrap     (wrap)
  );

  decode_scan #(.SEL_W(4), .DWELL_W(16)) dut4 (
    .clk      (clk),
    .rst_n    (rst4N),
    .enable   (enable4),
    .mode     (mode4),
    .data_in  (dataIn4),
    .load     (load4),
    .dwell    (dwell4),
    .data_out (dataOut4),
    .sel_out  (selOut4),
    .wrap     (wrap4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cold property on both instances, sampled every falling edge.
  always @(negedge clk) begin
    compared++;
    assert ($countones(~dataOut) <= 1) else begin
      mismatched++;
      $error("[TB] FAIL onecold8 data_out observed=%h expected=at most one low bit", dataOut);
    end
    compared++;
    assert ($countones(~dataOut4) <= 1) else begin
      mismatched++;
      $error("[TB] FAIL onecold16 data_out observed=%h expected=at most one low bit", dataOut4);
    end
  end

  function automatic logic [7:0] dec3(input logic [2:0] s);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << s);
  endfunction

  function automatic logic [15:0] dec4(input logic [3:0] s);
    logic [15:0] one;
    one = 16'd1;
    return ~(one << s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expData,
                             input logic [2:0] expS, input logic expWrap);
    compared++;
    assert (dataOut === expData) else begin
      mismatched++;
      $error("[TB] FAIL %s data_out observed=%h expected=%h", tag, dataOut, expData);
    end
    compared++;
    assert (selOut === expS) else begin
      mismatched++;
      $error("[TB] FAIL %s sel_out observed=%0d expected=%0d", tag, selOut, expS);
    end
    compared++;
    assert (wrap === expWrap) else begin
      mismatched++;
      $error("[TB] FAIL %s wrap observed=%b expected=%b", tag, wrap, expWrap);
    end
  endtask

  task automatic checkOutput4(input string tag, input logic [15:0] expData,
                              input logic [3:0] expS, input logic expWrap);
    compared++;
    assert (dataOut4 === expData) else begin
      mismatched++;
      $error("[TB] FAIL %s data_out observed=%h expected=%h", tag, dataOut4, expData);
    end
    compared++;
    assert (selOut4 === expS) else begin
      mismatched++;
      $error("[TB] FAIL %s sel_out observed=%0d expected=%0d", tag, selOut4, expS);
    end
    compared++;
    assert (wrap4 === expWrap) else begin
      mismatched++;
      $error("[TB] FAIL %s wrap observed=%b expected=%b", tag, wrap4, expWrap);
    end
  endtask

  // Hold cycles while the dwell counter runs up.
  task automatic holdCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput(tag, dec3(expSel), expSel, 1'b0);
    end
  endtask

  // One scan advance, including the blank cycle when configured.
  task automatic expectAdvance(input string tag);
    logic [2:0] nxt;
    nxt = expSel + 3'd1;
`ifdef DECODE_SCAN_BLANK_EN
    tick();
    checkOutput({tag, "_blank"}, 8'hFF, nxt, 1'b0);
`endif
    tick();
    expSel = nxt;
    checkOutput(tag, dec3(expSel), expSel, expSel == 3'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    expSel     = 3'd0;
    rst_n   = 1'b1;
    rst4N   = 1'b1;
    enable  = 1'b0;
    mode    = 1'b0;
    dataIn  = 3'd0;
    load    = 1'b0;
    dwell   = 16'd2;
    enable4 = 1'b1;
    mode4   = 1'b1;
    dataIn4 = 4'd0;
    load4   = 1'b0;
    dwell4  = 16'd0;
    #1;
    rst_n = 1'b0;
    rst4N = 1'b0;
    #2;
    checkOutput("reset", 8'hFF, 3'd0, 1'b0);

    // Leave reset between edges; first edge moves OFF to DIRECT.
    tick();
    tick();
    #2;
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();
    checkOutput("direct_entry", 8'hFF, 3'd0, 1'b0);

    load = 1'b1; dataIn = 3'd5;
    tick();
    load = 1'b0;
    checkOutput("load5", 8'b11011111, 3'd5, 1'b0);
    dataIn = 3'd2;
    tick();
    checkOutput("hold5", 8'b11011111, 3'd5, 1'b0);
    load = 1'b1; dataIn = 3'd0;
    tick();
    checkOutput("load0", 8'hFE, 3'd0, 1'b0);
    dataIn = 3'd7;
    tick();
    checkOutput("load7", 8'h7F, 3'd7, 1'b0);

    // enable=0 beats a simultaneous load.
    enable = 1'b0; dataIn = 3'd3;
    tick();
    load = 1'b0;
    checkOutput("disable_vs_load", 8'hFF, 3'd0, 1'b0);

    // Full scan lap with dwell=2; load toggling must be ignored.
    enable = 1'b1; mode = 1'b1; dwell = 16'd2;
    tick();
    expSel = 3'd0;
    checkOutput("scan_entry", 8'hFE, 3'd0, 1'b0);
    load = 1'b1; dataIn = 3'd6;
    for (int p = 0; p < 8; p++) begin
      holdCycles(2, "scan_hold");
      expectAdvance("scan_step");
    end
    load = 1'b0;

    // Advance to position 4, then drop enable for one cycle mid-dwell.
    for (int p = 0; p < 4; p++) begin
      holdCycles(2, "scan_hold");
      expectAdvance("scan_step");
    end
    holdCycles(1, "at4");
    enable = 1'b0;
    tick();
    checkOutput("drop_enable", 8'hFF, 3'd0, 1'b0);
    enable = 1'b1;
    tick();
    expSel = 3'd0;
    checkOutput("reenter", 8'hFE, 3'd0, 1'b0);

    // Live dwell: lower it below the running count, then zero.
    dwell = 16'd5;
    holdCycles(3, "dwell5_hold");
    dwell = 16'd1;
    expectAdvance("dwell_cut");
    dwell = 16'd0;
    expectAdvance("dwell0_a");
    expectAdvance("dwell0_b");

    // SCAN to DIRECT holds the picture until a load.
    mode = 1'b0;
    tick();
    checkOutput("to_direct", dec3(expSel), expSel, 1'b0);
    tick();
    checkOutput("direct_hold", dec3(expSel), expSel, 1'b0);
    load = 1'b1; dataIn = 3'd4;
    tick();
    load = 1'b0;
    checkOutput("load4", 8'hEF, 3'd4, 1'b0);

    // DIRECT to SCAN restarts at zero.
    mode = 1'b1;
    tick();
    expSel = 3'd0;
    checkOutput("to_scan", 8'hFE, 3'd0, 1'b0);

    // Asynchronous reset mid-dwell, observed before any edge.
    dwell = 16'd0;
    expectAdvance("pre_reset");
    dwell = 16'd5;
    holdCycles(1, "pre_reset_hold");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 8'hFF, 3'd0, 1'b0);
    tick();
    checkOutput("reset_held", 8'hFF, 3'd0, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    checkOutput("post_reset_scan", 8'hFE, 3'd0, 1'b0);

    // 16-output instance, dwell=0: one step per cycle (two with blanking).
    rst4N = 1'b1;
    tick();
    checkOutput4("w4_entry", 16'hFFFE, 4'd0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
`ifdef DECODE_SCAN_BLANK_EN
      tick();
      checkOutput4("w4_blank", 16'hFFFF, 4'(i), 1'b0);
`endif
      tick();
      checkOutput4("w4_step", dec4(4'(i)), 4'(i), i == 16);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
